// File: rtl/cus19_dm_access_unit.sv
// -----------------------------------------------------------------------------
// cus19_dm_access_unit
//
// Data-memory access unit at the IE/MEM boundary of the Custom-19 pipeline.
// Takes one memory request at a time over a valid/ready handshake, forms the
// address for the opcode, drives a synchronous data-memory port with a fixed
// read latency, and returns read data, a write acknowledge or an error. The
// pipeline is stalled for as long as a request is in flight.
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   req_valid_in/req_ready_out request handshake from the IE stage
//   opcode_in                  instruction opcode (LOAD / STORE / SP)
//   mem_rd_in, mem_wr_in       request direction
//   imm_addr_in                immediate address for LOAD / STORE
//   rs2_data_in                register address source for SP (zero-extended)
//   wr_data_in                 store data
//   dm_en/dm_we/dm_addr/dm_wdata  data-memory request port (dm_en is a pulse)
//   dm_rdata                   data-memory read data, MEM_LAT cycles after dm_en
//   rsp_valid/rsp_data/rsp_err one-cycle response strobe with data and error
//   stall_out                  pipeline stall, high whenever not ready
// -----------------------------------------------------------------------------
module cus19_dm_access_unit #(
    parameter int         ADDR_W   = 11,
    parameter int         DATA_W   = 19,
    parameter int         REG_W    = 8,
    parameter int         DEPTH    = 2048,
    parameter int         MEM_LAT  = 1,
    parameter logic [2:0] OP_LOAD  = 3'b001,
    parameter logic [2:0] OP_STORE = 3'b010,
    parameter logic [2:0] OP_SP    = 3'b100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [2:0]        opcode_in,
    input  logic              mem_rd_in,
    input  logic              mem_wr_in,
    input  logic [ADDR_W-1:0] imm_addr_in,
    input  logic [REG_W-1:0]  rs2_data_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              dm_en,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              stall_out
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    // When the memory fills the whole address space no address can be out of
    // range, and the comparison below would otherwise need an extra bit.
    localparam bit FULL_RANGE = (DEPTH >= (1 << ADDR_W));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [LAT_W-1:0]   lat_cnt;
    logic               is_store;

    logic               accept;
    logic [ADDR_W-1:0]  cls_addr;
    logic               cls_store;
    logic               cls_err;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return FULL_RANGE || (32'(a) < 32'(DEPTH));
    endfunction

    assign req_ready_out = (state == S_IDLE);
    assign stall_out     = ~req_ready_out;
    assign accept        = req_valid_in & req_ready_out;

    assign dm_en     = (state == S_ISSUE);
    assign dm_we     = dm_en & is_store;
    assign rsp_valid = (state == S_RESP);

    // Request classification: only the three legal opcode/direction pairs
    // reach the memory; everything else, and any address past the end of the
    // memory, is answered with an error and never touches the memory port.
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cls_addr  = '0;
        cls_store = 1'b0;
        cls_err   = 1'b0;
        if (mem_rd_in && !mem_wr_in && opcode_in == OP_LOAD) begin
            cls_addr = imm_addr_in;
        end else if (mem_rd_in && !mem_wr_in && opcode_in == OP_SP) begin
            cls_addr = ADDR_W'(rs2_data_in);
        end else if (mem_wr_in && !mem_rd_in && opcode_in == OP_STORE) begin
            cls_addr  = imm_addr_in;
            cls_store = 1'b1;
        end else begin
            cls_err = 1'b1;
        end
        if (!cls_err && !addr_in_range(cls_addr)) begin
            cls_err = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = cls_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_nx = is_store ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // dm_addr / dm_wdata double as the latched request: they are only loaded
    // by a request that will actually drive the memory, so they keep their
    // last driven value across errors and idle cycles. rsp_data / rsp_err are
    // loaded on the edge that enters RESP and hold until the next response.
    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            lat_cnt  <= '0;
            is_store <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_store <= cls_store;
                        if (cls_err) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end else begin
                            dm_addr <= cls_addr;
                            if (cls_store) begin
                                dm_wdata <= wr_data_in;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (is_store) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                    end else begin
                        // The capture happens in the WAIT cycle where the
                        // counter reaches zero, MEM_LAT cycles after ISSUE.
                        lat_cnt <= LAT_W'(MEM_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_data <= dm_rdata;
                        rsp_err  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cus19_dm_access_unit.sv
// -----------------------------------------------------------------------------
// tb_cus19_dm_access_unit
//
// Two instances of the access unit run side by side on one clock:
//   u0: MEM_LAT=3, DEPTH=1024 (upper half of the address space is illegal)
//   u1: MEM_LAT=1, DEPTH=2048 (whole address space legal)
// Each instance has its own memory device, driver, reference model and
// monitor. The driver pushes the expected memory access and response for
// every accepted request; the monitor pops and compares whenever the DUT
// raises dm_en or rsp_valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cus19_dm_access_unit;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 19;
    localparam int REG_W  = 8;
    localparam int NWORDS = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int                acc;
        int                lat;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    typedef struct {
        int                acc;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mem_t;

    for (genvar g = 0; g < 2; g++) begin : gen_u
        localparam int LAT = (g == 0) ? 3 : 1;
        localparam int DEP = (g == 0) ? 1024 : 2048;

        logic              rst;
        logic              req_valid;
        logic              req_ready;
        logic [2:0]        opcode;
        logic              mem_rd;
        logic              mem_wr;
        logic [ADDR_W-1:0] imm;
        logic [REG_W-1:0]  rs2;
        logic [DATA_W-1:0] wr_data;
        logic              dm_en;
        logic              dm_we;
        logic [ADDR_W-1:0] dm_addr;
        logic [DATA_W-1:0] dm_wdata;
        logic [DATA_W-1:0] dm_rdata;
        logic              rsp_valid;
        logic [DATA_W-1:0] rsp_data;
        logic              rsp_err;
        logic              stall;

        cus19_dm_access_unit #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .REG_W  (REG_W),
            .DEPTH  (DEP),
            .MEM_LAT(LAT)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid_in (req_valid),
            .req_ready_out(req_ready),
            .opcode_in    (opcode),
            .mem_rd_in    (mem_rd),
            .mem_wr_in    (mem_wr),
            .imm_addr_in  (imm),
            .rs2_data_in  (rs2),
            .wr_data_in   (wr_data),
            .dm_en        (dm_en),
            .dm_we        (dm_we),
            .dm_addr      (dm_addr),
            .dm_wdata     (dm_wdata),
            .dm_rdata     (dm_rdata),
            .rsp_valid    (rsp_valid),
            .rsp_data     (rsp_data),
            .rsp_err      (rsp_err),
            .stall_out    (stall)
        );

        function automatic string nm(input string s);
            return $sformatf("u%0d.%s", g, s);
        endfunction

        // Unwritten words read back a fixed per-address pattern.
        function automatic logic [DATA_W-1:0] init_val(input int a);
            return DATA_W'(a * 40503 + 12345 + g * 777);
        endfunction

        // ---------------- memory device (the DUT's data memory) -------------
        logic [DATA_W-1:0] dev_mem [NWORDS];
        bit                dev_wr  [NWORDS];
        logic [DATA_W-1:0] pipe_d  [LAT];
        logic              pipe_v  [LAT];
        logic [DATA_W-1:0] junk;

        always @(posedge clk) begin
            junk      <= DATA_W'($urandom);
            pipe_v[0] <= dm_en && !dm_we;
            pipe_d[0] <= dev_wr[int'(dm_addr)] ? dev_mem[int'(dm_addr)] : init_val(int'(dm_addr));
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            if (dm_en && dm_we) begin
                dev_mem[int'(dm_addr)] <= dm_wdata;
                dev_wr[int'(dm_addr)]  <= 1'b1;
            end
        end

        // Read data is only meaningful in its one valid cycle; garbage otherwise.
        assign dm_rdata = (pipe_v[LAT-1] === 1'b1) ? pipe_d[LAT-1] : junk;

        // ---------------- reference model --------------------------------
        logic [DATA_W-1:0] ref_mem [NWORDS];
        bit                ref_wr  [NWORDS];
        rsp_t              rq[$];
        mem_t              aq[$];
        bit                abort_busy = 1'b0;
        bit                done = 1'b0;

        function automatic logic [DATA_W-1:0] ref_rd(input int a);
            return ref_wr[a] ? ref_mem[a] : init_val(a);
        endfunction

        function automatic void model(input logic [2:0] op, input logic rd, input logic wr,
                                      input logic [ADDR_W-1:0] im, input logic [REG_W-1:0] r2,
                                      output logic err, output logic st, output int a);
            err = 1'b0;
            st  = 1'b0;
            a   = 0;
            if (rd && !wr && op == 3'b001) a = int'(im);
            else if (rd && !wr && op == 3'b100) a = int'(r2);
            else if (wr && !rd && op == 3'b010) begin
                a  = int'(im);
                st = 1'b1;
            end else err = 1'b1;
            if (!err && a >= DEP) err = 1'b1;
        endfunction

        // ---------------- driver -----------------------------------------
        task automatic do_req(input logic [2:0] op, input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] im, input logic [REG_W-1:0] r2,
                              input logic [DATA_W-1:0] wd, input bit hold);
            int   guard;
            logic e;
            logic st;
            int   a;
            rsp_t r;
            mem_t m;
            @(negedge clk);
            opcode    = op;
            mem_rd    = rd;
            mem_wr    = wr;
            imm       = im;
            rs2       = r2;
            wr_data   = wd;
            req_valid = 1'b1;
            guard = 0;
            while (req_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                check(nm("accept_timeout"), 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            model(op, rd, wr, im, r2, e, st, a);
            r.acc  = cyc;
            r.err  = e;
            r.lat  = e ? 1 : (st ? 2 : LAT + 2);
            r.data = (e || st) ? '0 : ref_rd(a);
            rq.push_back(r);
            if (!e) begin
                m.acc   = cyc;
                m.addr  = ADDR_W'(a);
                m.we    = st;
                m.wdata = wd;
                aq.push_back(m);
                if (st) begin
                    ref_mem[a] = wd;
                    ref_wr[a]  = 1'b1;
                end
            end
            if (hold) begin
                // Keep the request asserted through the whole transaction;
                // only one transaction may result.
                guard = 0;
                while (guard < 50) begin
                    @(negedge clk);
                    guard++;
                    if (rsp_valid === 1'b1) break;
                end
                if (guard >= 50) check(nm("hold_rsp_timeout"), 32'(rsp_valid), 32'd1);
                req_valid = 1'b0;
            end else begin
                // Scramble the inputs while busy; they must be ignored.
                req_valid = 1'b0;
                opcode    = 3'($urandom);
                mem_rd    = 1'($urandom);
                mem_wr    = 1'($urandom);
                imm       = ADDR_W'($urandom);
                rs2       = REG_W'($urandom);
                wr_data   = DATA_W'($urandom);
            end
        endtask

        task automatic check_reset_outputs();
            check(nm("rst.dm_en"),     32'(dm_en),     32'd0);
            check(nm("rst.dm_we"),     32'(dm_we),     32'd0);
            check(nm("rst.dm_addr"),   32'(dm_addr),   32'd0);
            check(nm("rst.dm_wdata"),  32'(dm_wdata),  32'd0);
            check(nm("rst.rsp_valid"), 32'(rsp_valid), 32'd0);
            check(nm("rst.rsp_data"),  32'(rsp_data),  32'd0);
            check(nm("rst.rsp_err"),   32'(rsp_err),   32'd0);
            check(nm("rst.ready"),     32'(req_ready), 32'd1);
            check(nm("rst.stall"),     32'(stall),     32'd0);
        endtask

        task automatic random_reqs(input int n);
            int          k;
            logic [2:0]  op;
            logic        rd;
            logic        wr;
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 9);
                if (k <= 2) begin
                    op = 3'b001; rd = 1'b1; wr = 1'b0;
                end else if (k <= 4) begin
                    op = 3'b010; rd = 1'b0; wr = 1'b1;
                end else if (k <= 6) begin
                    op = 3'b100; rd = 1'b1; wr = 1'b0;
                end else begin
                    op = 3'($urandom); rd = 1'($urandom); wr = 1'($urandom);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                do_req(op, rd, wr, ADDR_W'($urandom), REG_W'($urandom), DATA_W'($urandom),
                       $urandom_range(0, 3) == 0);
            end
        endtask

        task automatic finish_checks();
            repeat (LAT + 6) @(negedge clk);
            check(nm("rsp_queue_drained"), 32'(rq.size()), 32'd0);
            check(nm("mem_queue_drained"), 32'(aq.size()), 32'd0);
            done = 1'b1;
        endtask

        task automatic start_up();
            rst       = 1'b1;
            req_valid = 1'b0;
            opcode    = '0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            imm       = '0;
            rs2       = '0;
            wr_data   = '0;
            repeat (2) @(negedge clk);
            check_reset_outputs();
            #1 rst = 1'b0;
        endtask

        // ---------------- monitor ----------------------------------------
        always @(negedge clk) begin
            rsp_t r;
            mem_t m;
            check(nm("ready"), 32'(req_ready), 32'(rq.size() == 0 && !abort_busy));
            check(nm("stall"), 32'(stall),     32'(rq.size() != 0 || abort_busy));
            if (dm_en === 1'b1) begin
                if (aq.size() == 0) begin
                    check(nm("dm_en_unexpected"), 32'(dm_en), 32'd0);
                end else begin
                    m = aq.pop_front();
                    check(nm("dm_addr"),   32'(dm_addr),     32'(m.addr));
                    check(nm("dm_we"),     32'(dm_we),       32'(m.we));
                    check(nm("dm_en_lat"), 32'(cyc + 1 - m.acc), 32'd1);
                    if (m.we) check(nm("dm_wdata"), 32'(dm_wdata), 32'(m.wdata));
                end
            end
            if (rsp_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    check(nm("rsp_valid_unexpected"), 32'(rsp_valid), 32'd0);
                end else begin
                    r = rq.pop_front();
                    check(nm("rsp_err"),  32'(rsp_err),  32'(r.err));
                    check(nm("rsp_data"), 32'(rsp_data), 32'(r.data));
                    check(nm("rsp_lat"),  32'(cyc + 1 - r.acc), 32'(r.lat));
                end
            end
        end

        // ---------------- stimulus ---------------------------------------
        if (g == 0) begin : g_stim
            // MEM_LAT=3, DEPTH=1024
            initial begin
                start_up();
                do_req(3'b100, 1'b1, 1'b0, 11'h000, 8'hFF, '0, 1'b1);      // SP rs2=0xFF, held valid
                do_req(3'b001, 1'b1, 1'b0, 11'h400, 8'h00, '0, 1'b0);      // LOAD at DEPTH: error
                do_req(3'b001, 1'b1, 1'b0, 11'h3FF, 8'h00, '0, 1'b0);      // LOAD at DEPTH-1: legal
                do_req(3'b010, 1'b0, 1'b1, 11'h400, 8'h00, 19'h12345, 1'b0); // STORE at DEPTH: error
                do_req(3'b010, 1'b0, 1'b1, 11'h3FF, 8'h00, 19'h2AAAA, 1'b0); // STORE at DEPTH-1
                do_req(3'b001, 1'b1, 1'b0, 11'h3FF, 8'h00, '0, 1'b0);      // read it back
                do_req(3'b010, 1'b0, 1'b1, 11'h0FF, 8'h00, 19'h13579, 1'b1); // held STORE
                do_req(3'b100, 1'b1, 1'b0, 11'h000, 8'hFF, '0, 1'b0);      // SP sees the store

                // Reset while the read is waiting on memory: dropped silently.
                @(negedge clk);
                opcode = 3'b001; mem_rd = 1'b1; mem_wr = 1'b0; imm = 11'h010; req_valid = 1'b1;
                while (req_ready !== 1'b1) @(negedge clk);
                @(posedge clk);
                #1;
                req_valid  = 1'b0;
                abort_busy = 1'b1;
                aq.push_back('{acc: cyc, addr: 11'h010, we: 1'b0, wdata: '0});
                @(posedge clk);
                @(posedge clk);
                #2 rst = 1'b1;
                abort_busy = 1'b0;
                #1 check_reset_outputs();
                @(negedge clk);
                #2 rst = 1'b0;
                repeat (6) @(negedge clk);
                do_req(3'b001, 1'b1, 1'b0, 11'h010, 8'h00, '0, 1'b0);

                random_reqs(40);
                finish_checks();
            end
        end else begin : g_stim
            // MEM_LAT=1, DEPTH=2048 (no address out of range)
            initial begin
                start_up();
                do_req(3'b010, 1'b0, 1'b1, 11'h123, 8'h00, 19'h5A5A5, 1'b0); // preload
                do_req(3'b001, 1'b1, 1'b0, 11'h123, 8'h00, '0, 1'b0);      // LOAD 0x123
                do_req(3'b010, 1'b0, 1'b1, 11'h7FF, 8'h00, 19'h7FFFF, 1'b0); // STORE top word
                do_req(3'b001, 1'b1, 1'b0, 11'h7FF, 8'h00, '0, 1'b1);      // LOAD top word, held
                do_req(3'b010, 1'b1, 1'b0, 11'h010, 8'h00, '0, 1'b0);      // rd with STORE opcode
                do_req(3'b001, 1'b1, 1'b1, 11'h010, 8'h00, 19'h11111, 1'b0); // rd and wr
                do_req(3'b001, 1'b0, 1'b0, 11'h010, 8'h00, '0, 1'b0);      // neither
                do_req(3'b001, 1'b0, 1'b1, 11'h010, 8'h00, 19'h22222, 1'b1); // wr with LOAD opcode
                do_req(3'b100, 1'b1, 1'b0, 11'h000, 8'h23, '0, 1'b0);      // SP 0x23
                random_reqs(40);
                finish_checks();
            end
        end
    end

    initial begin
        int guard;
        guard = 0;
        while (!(gen_u[0].done && gen_u[1].done) && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        check("all_done", 32'(gen_u[0].done && gen_u[1].done), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cus19_dm_access_unit.md
Name: cus19_dm_access_unit

Overview:
- Parametrised, sequential data-memory access unit for the IE/MEM boundary of the Custom-19 pipeline.
- Accepts one load, store or SP (register-indirect) memory request per transaction over a valid/ready handshake.
- Forms the address per opcode, drives a synchronous data-memory port with configurable read latency, and returns read data or a write acknowledge.
- Range-checks addresses against the memory depth and asserts a pipeline stall while a transaction is in flight.

Parameters:
- ADDR_W, 11, data-memory address width.
- DATA_W, 19, data word width.
- REG_W, 8, width of rs2 register value used as SP address (zero-extended to ADDR_W; REG_W <= ADDR_W).
- DEPTH, 2048, number of valid words; address >= DEPTH is out of range.
- MEM_LAT, 1, data-memory read latency in cycles (>= 1).
- OP_LOAD, 3'b001, opcode: read at imm_addr_in.
- OP_STORE, 3'b010, opcode: write wr_data_in at imm_addr_in.
- OP_SP, 3'b100, opcode: read at zero-extended rs2_data_in.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_in  in  1  request valid from IE stage.
- req_ready_out  out  1  unit can accept a request.
- opcode_in  in  3  instruction opcode.
- mem_rd_in  in  1  request is a read.
- mem_wr_in  in  1  request is a write.
- imm_addr_in  in  ADDR_W  immediate address (LOAD/STORE).
- rs2_data_in  in  REG_W  register address source (SP).
- wr_data_in  in  DATA_W  store data.
- dm_en  out  1  memory port enable (one-cycle pulse).
- dm_we  out  1  memory write enable (qualified by dm_en).
- dm_addr  out  ADDR_W  memory address.
- dm_wdata  out  DATA_W  memory write data.
- dm_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the dm_en cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  DATA_W  read data (0 for writes and errors).
- rsp_err  out  1  response is an error (qualified by rsp_valid).
- stall_out  out  1  pipeline stall, equals ~req_ready_out.

Behaviour:
- Reset (async, any state): state=IDLE; latency counter=0.
  - Outputs reset to: req_ready_out=1, stall_out=0, dm_en=0, dm_we=0, dm_addr=0, dm_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - An in-flight transaction is dropped silently; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP. req_ready_out=1 only in IDLE.
- IDLE: on req_valid_in & req_ready_out, latch the request and classify it:
  - mem_rd_in=1, mem_wr_in=0, opcode OP_LOAD: address = imm_addr_in.
  - mem_rd_in=1, mem_wr_in=0, opcode OP_SP: address = {zeros, rs2_data_in}.
  - mem_wr_in=1, mem_rd_in=0, opcode OP_STORE: address = imm_addr_in, write data = wr_data_in.
  - Anything else (both or neither of rd/wr, opcode/direction mismatch): error.
  - Latched address >= DEPTH: error.
  - Error: go to RESP directly; no dm_en is issued. Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - dm_en=1, dm_addr=latched address, dm_we=1 for a store.
  - Store: go to RESP.
  - Read: load counter=MEM_LAT-1 and go to WAIT.
- WAIT: the cycle with counter==0 captures dm_rdata, then goes to RESP; otherwise decrement.
  - Capture occurs exactly MEM_LAT cycles after the ISSUE cycle.
- RESP (1 cycle): rsp_valid=1.
  - rsp_data = captured data for reads, 0 for stores and errors.
  - rsp_err set as classified.
  - Next state IDLE. A new request is accepted no earlier than the cycle after RESP.
- Latency from accept edge to rsp_valid:
  - read: MEM_LAT+2 cycles.
  - store: 2 cycles.
  - error: 1 cycle.
- dm_addr and dm_wdata hold their last driven value when dm_en=0. rsp_data and rsp_err hold until the next RESP.
- Inputs are ignored outside IDLE; req_valid_in held high during busy creates no extra transaction.
- Address math is unsigned; no wrap. Boundary addresses:
  - DEPTH-1: legal.
  - DEPTH: error.
  - When DEPTH = 2^ADDR_W, no address is out of range.

Test Plan:
- LOAD opcode=001, imm=0x123, MEM_LAT=1, memory[0x123]=0x5A5A5 -> dm_en at T+1 with dm_addr=0x123, dm_we=0; rsp_valid at T+3 with rsp_data=0x5A5A5, rsp_err=0; stall_out high T+1..T+3.
- SP opcode=100, rs2=0xFF, MEM_LAT=3 -> dm_addr=0x0FF; rsp_valid at T+5 with correct data; req_valid_in held high throughout yields exactly one transaction.
- STORE opcode=010, imm=0x7FF, wr_data=0x7FFFF -> dm_en=dm_we=1 at T+1 with dm_wdata=0x7FFFF; rsp_valid at T+2, rsp_data=0, rsp_err=0.
- DEPTH=1024, LOAD imm=0x400 -> no dm_en; rsp_valid at T+1 with rsp_err=1. Repeat with imm=0x3FF -> normal read.
- Illegal requests: mem_rd_in=1 with opcode=010; mem_rd_in=mem_wr_in=1 -> each gives an error response, no dm_en.
- Assert rst during WAIT (MEM_LAT=3) -> all outputs 0 immediately, req_ready_out=1, no rsp_valid; next request completes normally.
